alu_control_unit: RTL

Multi-cycle controller that fetches 12-bit instructions from program memory, decodes them, and drives the ALU's enable, mode, flag and operand inputs. It writes ALU results back to the accumulator or data memory, owns the 4-bit status register, and resolves flag-conditional branches. It sits between program memory, data memory, and the combinational ALU, which is its sole execution resource.

---
 rtl/alu_control_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/alu_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE controller wrapped around a combinational ALU.
// Owns PC, IR, accumulator and the {Z,C,S,O} status register.
module alu_control_unit #(
    parameter int               PC_W     = 8,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [PC_W-1:0]  pmem_addr,
    input  logic [11:0]      pmem_data,
    output logic [3:0]       dmem_addr,
    input  logic [7:0]       dmem_do,
    output logic             dmem_we,
    output logic             alu_e,
    output logic [3:0]       alu_mode,
    output logic [3:0]       alu_cflags,
    output logic [7:0]       alu_op1,
    output logic [7:0]       alu_op2,
    input  logic [3:0]       alu_flags,
    input  logic [7:0]       alu_out,
    output logic [3:0]       status,
    output logic [7:0]       acc,
    output logic [PC_W-1:0]  pc,
    output logic             halted
);

    // state   | meaning
    // FETCH   | pmem_addr = PC, instruction read in flight
    // DECODE  | IR <- pmem_data, PC <- PC+1
    // EXECUTE | perform IR (ALU op, branch, jump, load, nop, halt)
    // HALT    | absorbing until rst
    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [11:0]     ir_q, ir_d;
    logic [7:0]      acc_q, acc_d;
    logic [3:0]      status_q, status_d;

    logic            is_alu;
    logic            keep_carry;
    logic [PC_W-1:0] br_target;

    assign is_alu     = ~ir_q[11];
    // The ALU leaves carry undriven in modes x010..x110, so the old C survives.
    assign keep_carry = (ir_q[9:7] >= 3'd2) && (ir_q[9:7] <= 3'd6);
    assign br_target  = PC_W'(ir_q[7:0]);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        acc_d    = acc_q;
        status_d = status_q;
        alu_e    = 1'b0;
        dmem_we  = 1'b0;
        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = pmem_data;
                pc_d    = pc_q + 1'b1;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                if (is_alu) begin
                    alu_e = 1'b1;
                    if (ir_q[6]) begin
                        dmem_we = ~rst;
                    end else begin
                        acc_d = alu_out;
                    end
                    status_d = alu_flags;
                    if (keep_carry) begin
                        status_d[2] = status_q[2];
                    end
                end else if (!ir_q[10]) begin
                    // 3 - sel on a 2-bit field is its bitwise inverse
                    if (status_q[~ir_q[9:8]]) begin
                        pc_d = br_target;
                    end
                end else begin
                    case (ir_q[9:8])
                        2'b00:   pc_d    = br_target;
                        2'b01:   acc_d   = ir_q[7:0];
                        2'b10:   ;
                        default: state_d = S_HALT;
                    endcase
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            acc_q    <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            acc_q    <= acc_d;
            status_q <= status_d;
        end
    end

    assign pmem_addr  = pc_q;
    assign dmem_addr  = ir_q[3:0];
    assign alu_mode   = ir_q[10:7];
    assign alu_cflags = status_q;
    assign alu_op1    = acc_q;
    assign alu_op2    = dmem_do;
    assign status     = status_q;
    assign acc        = acc_q;
    assign pc         = pc_q;
    assign halted     = (state_q == S_HALT);

endmodule
